// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus for one pipeline boundary: upstream in_* side and downstream out_* side.
// A word moves on an edge where valid and ready are both 1; valid holds until that edge.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a 2-entry skid buffer, synchronous flush, bubble
// control masking and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cnt_clr,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;

  logic main_valid;
  logic in_fire;
  logic out_fire;

  assign main_valid = (state_q != EMPTY);
  assign in_fire    = bus.in_valid & in_ready_q;
  assign out_fire   = main_valid & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = ONE;
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
        end else if (in_fire) begin
          state_d     = FULL;
          skid_data_d = bus.in_data;
          skid_ctrl_d = bus.in_ctrl;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only kills the valid bits; stale data is hidden by the ctrl mask.
    if (flush) begin
      state_d = EMPTY;
    end
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (cnt_clr) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (main_valid && !bus.out_ready && stall_q != CNT_MAX) begin
        stall_d = stall_q + 1'b1;
      end
      if (!main_valid && bus.out_ready && bubble_q != CNT_MAX) begin
        bubble_d = bubble_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
      bubble_q    <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q & {CTRL_W{main_valid}};
  assign occupancy     = state_q;
  assign stall_cnt     = stall_q;
  assign bubble_cnt    = bubble_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: expected words are queued by the tests and a
// monitor pops and compares every word the stage hands downstream.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             cnt_clr;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [1:0]       state_dbg;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .bus        (bus.slave),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .state_dbg_o(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [CTRL_W+DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    exp_q.push_back({c, d});
  endtask

  // driver: present one word and hold it until the edge that accepts it
  task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_ctrl  = c;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [CTRL_W+DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0h/%0h, expected no word", bus.out_ctrl, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e[DATA_W-1:0]));
          chk("out_ctrl", 64'(bus.out_ctrl), 64'(e[CTRL_W+DATA_W-1:DATA_W]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_ctrl = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reset mid-stream with two words held
    send(32'hD1, 8'h0F);
    send(32'hD2, 8'h0F);
    @(negedge clk);
    chk("pre_rst_occupancy", 64'(occupancy), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // streaming, one word per cycle
    bus.out_ready = 1'b1;
    push(32'h11, 8'h01);
    push(32'h22, 8'h02);
    push(32'h33, 8'h03);
    fork
      begin
        send(32'h11, 8'h01);
        send(32'h22, 8'h02);
        send(32'h33, 8'h03);
      end
      begin
        logic [DATA_W-1:0] vec [3];
        vec[0] = 32'h11;
        vec[1] = 32'h22;
        vec[2] = 32'h33;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stream_out_valid", 64'(bus.out_valid), 64'd1);
          chk("stream_latency_data", 64'(bus.out_data), 64'(vec[i]));
          chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
          @(posedge clk);
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // backpressure: out_ready low for 3 cycles after 0xA1 is presented
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 6; i++) push(DATA_W'(32'hA0 + i), CTRL_W'(8'h10 + i));
    fork
      begin
        for (int i = 0; i < 6; i++) send(DATA_W'(32'hA0 + i), CTRL_W'(8'h10 + i));
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp_occupancy", 64'(occupancy), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd3);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // flush with two words held and a word offered
    bus.out_ready = 1'b0;
    send(32'hB1, 8'hFF);
    send(32'hB2, 8'hFF);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h77;
    bus.in_ctrl = 8'hFF;
    flush = 1'b1;
    @(negedge clk);
    chk("preflush_occupancy", 64'(occupancy), 64'd2);
    chk("preflush_out_ctrl", 64'(bus.out_ctrl), 64'hFF);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);

    // flush in EMPTY discards a word that would otherwise be accepted
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h78;
    bus.in_ctrl = 8'hFF;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // out_fire and flush in the same ONE cycle
    push(32'hC1, 8'h5A);
    send(32'hC1, 8'h5A);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fire_flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fire_flush_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // bubble counting and saturation
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bubble_cnt_5", 64'(bubble_cnt), 64'd5);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("bubble_cnt_sat", 64'(bubble_cnt), 64'd15);
    chk("stall_cnt_idle", 64'(stall_cnt), 64'd0);
    #4;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("bubble_cnt_clr", 64'(bubble_cnt), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bubble_cnt_after_clr", 64'(bubble_cnt), 64'd1);

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: the generic successor to the fixed per-stage latch registers between IF/ID/EX/MEM/WB. It adds a valid/ready handshake with a 2-entry skid buffer so that backpressure is fully registered. It also provides synchronous flush and control-field masking, so that RegWrite- and MemWrite-type bits are never seen asserted on a bubble, plus saturating stall/bubble performance counters. It is instantiated once per pipeline boundary; the datapath fields are packed into `in_data`, and the control bits that must be killed on a bubble go in `in_ctrl`.

## Interface
- DATA_W, 32, width of the payload bus (ALU result, memory data, NPC, etc. packed).
- CTRL_W, 8, width of the control bus; forced to zero whenever the output is invalid.
- CNT_W, 16, width of each performance counter.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all stage contents.
- cnt_clr  in  1  synchronous clear of both counters.
- in_valid  in  1  upstream has a word.
- in_ready  out  1  stage can accept a word; registered.
- in_data  in  DATA_W  payload in.
- in_ctrl  in  CTRL_W  control in.
- out_valid  out  1  stage holds a word for downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload out; registered.
- out_ctrl  out  CTRL_W  control out; equals the stored ctrl & {CTRL_W{out_valid}}.
- occupancy  out  2  number of words held (0, 1 or 2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1.

## Operation
- Storage is a main register (drives out_*) and a skid register, each with its own valid bit.
- in_ready = !skid_valid, taken directly from a flop.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State follows occupancy: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: in_fire -> ONE, main<=in. Otherwise stay.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire only -> FULL, skid<=in. out_fire only -> EMPTY. Neither -> hold.
  - FULL: in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
- flush has priority over every transfer.
  - Next state is EMPTY with both valid bits cleared.
  - A word presented with in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle is a completed transfer; downstream keeps the word.
  - Data flops may keep stale values; out_ctrl reads 0 because of the valid mask.
- Words leave in arrival order; none is duplicated or dropped except by flush.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 (no wrap).
  - cnt_clr clears them to 0 next edge and overrides the increment.
  - flush does not affect the counters.
  - A flush cycle is counted according to its pre-edge out_valid/out_ready.

## Timing
- Reset values: in_ready=1; out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, bubble_cnt=0. Skid data is also 0.
- Latency: in_fire at edge N gives out_valid=1 with that word after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle while out_ready=1.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- in_ready falls one cycle after out_ready falls with data arriving. The skid absorbs the in-flight word.
- in_ready rises the cycle after the FULL->ONE drain.
- rst mid-operation: all state is cleared immediately (asynchronously), irrespective of clk.

## Test plan
- Reset: assert rst mid-stream with occupancy=2 -> next observation in_ready=1, out_valid=0, out_ctrl=0, occupancy=0, counters 0.
- Streaming: out_ready=1, send 0x11,0x22,0x33 back-to-back -> outputs 0x11,0x22,0x33 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Backpressure: stream 0xA0..0xA5, drop out_ready for 3 cycles after 0xA1 is presented. Required:
  - occupancy reaches 2, then in_ready=0.
  - stall_cnt=3.
  - After release, the sequence 0xA0..0xA5 is intact, with no loss or duplication.
- Flush: occupancy=2 (ctrl 0xFF in both), pulse flush with in_valid=1 carrying 0x77. Required:
  - Next cycle out_valid=0, out_ctrl=0x00, occupancy=0.
  - 0x77 never appears.
- Bubbles/saturation with CNT_W=4: out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt=15 (saturated). Pulse cnt_clr -> bubble_cnt=0.
- Simultaneous out_fire+flush in ONE: downstream samples the word once; next cycle out_valid=0.
